timer_disp_scan: RTL and testbench



---
 rtl/timer_disp_scan.sv | 129 ++++++++++++
 tb/tb_timer_disp_scan.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/timer_disp_scan.sv
// Scans a packed-BCD MM:SS value onto a 4-digit common-anode 7-segment display.
// Handles frame-coherent snapshots, anti-ghost guard, leading-zero blanking, colon and expiry blink.
module timer_disp_scan #(
    parameter int SCAN_DIV  = 100000,
    parameter int BLINK_DIV = 50000000,
    parameter int GUARD     = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [16:1] timer,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    logic [SW-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [16:1]   snap_q, snap_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d;
    logic          load_q, load_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    logic          scan_wrap;
    logic          expired;
    logic          blank;
    logic [3:0]    digit;

    always_comb begin
        scan_wrap   = (scan_cnt_q == SW'(SCAN_DIV - 1));
        scan_cnt_d  = scan_wrap ? '0 : scan_cnt_q + SW'(1);
        idx_d       = scan_wrap ? idx_q + 2'd1 : idx_q;
        load_d      = 1'b0;

        // load_q is set through reset so the first clock afterwards captures the bus
        snap_d = snap_q;
        if (load_q || (scan_wrap && idx_q == 2'd3)) begin
            snap_d = timer;
        end

        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (!start) begin
            blink_cnt_d = '0;
            phase_d     = 1'b1;
        end else if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
        end

        case (idx_q)
            2'd0:    digit = snap_q[4:1];
            2'd1:    digit = snap_q[8:5];
            2'd2:    digit = snap_q[12:9];
            default: digit = snap_q[16:13];
        endcase

        expired = start && (snap_q == 16'h0000);
        blank   = ((idx_q == 2'd3) && (digit == 4'd0)) || (expired && !phase_q);
        seg_d   = blank ? 7'b1111111 : bcd_to_seg(digit);
        an_d    = (scan_cnt_q < SW'(GUARD)) ? 4'b1111 : ~(4'b0001 << idx_q);

        dp_d = 1'b1;
        if (idx_q == 2'd2) begin
            if (!start) begin
                dp_d = 1'b0;
            end else if (expired) begin
                dp_d = 1'b1;
            end else begin
                dp_d = ~phase_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            scan_cnt_q  <= '0;
            idx_q       <= 2'd0;
            snap_q      <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
            load_q      <= 1'b1;
            an_q        <= 4'b1111;
            seg_q       <= 7'b1111111;
            dp_q        <= 1'b1;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            idx_q       <= idx_d;
            snap_q      <= snap_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            load_q      <= load_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_timer_disp_scan.sv
// Scoreboard bench for timer_disp_scan: a cycle-count reference model predicts each
// registered display word, and a negedge monitor compares it against the DUT.
module tb_timer_disp_scan;

    localparam int SD = 8;
    localparam int BD = 32;
    localparam int GD = 2;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        int         idx;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        start = 1'b0;
    logic [16:1] timer = 16'h0537;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int checks = 0;
    int errors = 0;

    exp_t exp_q[$];

    // reference model state: edges since reset release, displayed value, consecutive running edges
    int          m_c    = 0;
    logic [15:0] m_snap = 16'h0000;
    int          m_r    = 0;

    logic [6:0] dec_tab [16];

    timer_disp_scan #(.SCAN_DIV(SD), .BLINK_DIV(BD), .GUARD(GD)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .start (start),
        .timer (timer),
        .an    (an),
        .seg   (seg),
        .dp    (dp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got an/seg/dp=%03h required %03h", name, $time, act, req);
        end
    endtask

    initial begin
        dec_tab[0]  = 7'b1000000; dec_tab[1]  = 7'b1111001;
        dec_tab[2]  = 7'b0100100; dec_tab[3]  = 7'b0110000;
        dec_tab[4]  = 7'b0011001; dec_tab[5]  = 7'b0010010;
        dec_tab[6]  = 7'b0000010; dec_tab[7]  = 7'b1111000;
        dec_tab[8]  = 7'b0000000; dec_tab[9]  = 7'b0010000;
        for (int i = 10; i < 16; i++) dec_tab[i] = 7'b0111111;
    end

    // Reference model: the word registered at an edge is a pure function of how many
    // edges have elapsed, the frame snapshot and how long start has been held.
    initial begin
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) begin
                m_c    = 0;
                m_snap = 16'h0000;
                m_r    = 0;
                exp_q.delete();
            end else begin
                exp_t e;
                int pos, ix, dig;
                bit ph, expd, blank;
                pos   = m_c % SD;
                ix    = (m_c / SD) % 4;
                dig   = int'((m_snap >> (4 * ix)) & 16'hF);
                ph    = ((m_r / BD) % 2) == 0;
                expd  = start && (m_snap == 16'h0000);
                blank = (ix == 3 && dig == 0) || (expd && !ph);
                e.idx = ix;
                e.an  = (pos < GD) ? 4'b1111 : ~(4'b0001 << ix);
                e.seg = blank ? 7'b1111111 : dec_tab[dig];
                if (ix != 2)      e.dp = 1'b1;
                else if (!start)  e.dp = 1'b0;
                else if (expd)    e.dp = 1'b1;
                else              e.dp = !ph;
                exp_q.push_back(e);
                if (m_c == 0) m_snap = timer;
                m_c++;
                if (m_c % (4 * SD) == 0) m_snap = timer;
                if (start) m_r++;
                else       m_r = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t e;
                string nm;
                e = exp_q.pop_front();
                nm = $sformatf("slot_idx%0d", e.idx);
                chk(nm, {an, seg, dp}, {e.an, e.seg, e.dp});
            end
        end
    end

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int guard;
        rstn  = 1'b0;
        start = 1'b0;
        timer = 16'h0537;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_state", {an, seg, dp}, {4'b1111, 7'b1111111, 1'b1});
        rstn = 1'b1;

        // static 05:37 with colon steady, two frames plus
        run(4 * SD * 2 + 5);

        // tearing: frame showing 10:00 keeps it after the bus changes mid-frame
        timer = 16'h1000;
        guard = 0;
        while (!(m_snap == 16'h1000 && ((m_c / SD) % 4) == 1) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (guard >= 200) begin
            errors++;
            $display("FAIL tear_setup timeout: waited %0d cycles required < 200", guard);
        end
        timer = 16'h0959;
        run(4 * SD * 2 + 3);

        // invalid BCD digit shows a dash
        timer = 16'h12A4;
        run(4 * SD * 2 + 3);

        // expired countdown blinks, then start drops while expired
        start = 1'b1;
        timer = 16'h0000;
        run(4 * SD * 5);
        start = 1'b0;
        run(4 * SD + 7);

        // running countdown: colon blinks
        start = 1'b1;
        timer = 16'h0312;
        run(4 * SD * 4);

        // randomized bus values and start toggles
        for (int k = 0; k < 14; k++) begin
            logic [15:0] v;
            v = 16'h0000;
            for (int d = 0; d < 4; d++) begin
                int nib;
                nib = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
                v = v | (16'(nib) << (4 * d));
            end
            if ($urandom_range(0, 5) == 0) v = 16'h0000;
            timer = v;
            start = ($urandom_range(0, 3) != 0);
            run(int'($urandom_range(10, 70)));
        end

        // asynchronous reset in the middle of the idx2 slot
        start = 1'b1;
        timer = 16'h2345;
        guard = 0;
        while (!(((m_c / SD) % 4) == 2 && (m_c % SD) == 4) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (guard >= 200) begin
            errors++;
            $display("FAIL midslot_setup timeout: waited %0d cycles required < 200", guard);
        end
        chk("pre_reset_active", {an, 8'h00}, {4'b1011, 8'h00});
        #1 rstn = 1'b0;
        #1 chk("async_reset", {an, seg, dp}, {4'b1111, 7'b1111111, 1'b1});
        run(3);
        rstn = 1'b1;
        run(4 * SD * 2 + 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
